// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative multiply/divide unit.
//
// Holds the architectural HI/LO registers. MTHI/MTLO writes arrive on
// hilo_we/hi_in/lo_in. MULT/MULTU/DIV/DIVU run one shift-add or restoring
// subtract step per cycle for DATA_W cycles, then spend one FIX cycle applying
// signs and writing {hi,lo}.
//
// Ports
//   clk, resetn        rising-edge clock, asynchronous active-low reset
//   start, op, a, b    issue an operation (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hilo_we, hi_in,    direct HI/LO writes ([1] HI, [0] LO), honoured only when idle
//   lo_in
//   rd_req             MFHI/MFLO in EX; causes a stall while busy
//   flush              abort any operation; HI/LO are left untouched
//   hi, lo             HI/LO registers
//   busy               operation in flight
//   done               one-cycle pulse after an operation writes HI/LO
//   stall_req          busy and a HI/LO-dependent request is present
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              rd_req,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall_req
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [DATA_W-1:0] acc_hi_reg;   // partial product high half / running remainder
  logic [DATA_W-1:0] acc_lo_reg;   // multiplier bits / dividend bits becoming quotient
  logic [DATA_W-1:0] opb_reg;      // multiplicand / divisor magnitude
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              is_div_reg;
  logic              neg_q_reg;    // negate product or quotient
  logic              neg_r_reg;    // negate remainder (dividend sign)
  logic              done_reg;

  // Operand conditioning: signed ops work on magnitudes, signs fixed up in FIX.
  logic              op_signed;
  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  assign op_signed = ~op[0];
  assign sa        = op_signed & a[DATA_W-1];
  assign sb        = op_signed & b[DATA_W-1];
  assign a_mag     = sa ? -a : a;
  assign b_mag     = sb ? -b : b;

  // One iteration step.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;

  assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
  assign div_shift = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_reg});
  // When div_ge holds the true difference is below the divisor, so the low
  // DATA_W bits of the subtraction are exact.
  assign div_rem   = div_shift[DATA_W-1:0] - opb_reg;

  always_comb begin
    step_hi = acc_hi_reg;
    step_lo = acc_lo_reg;
    if (is_div_reg) begin
      step_hi = div_ge ? div_rem : div_shift[DATA_W-1:0];
      step_lo = {acc_lo_reg[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo_reg[DATA_W-1:1]};
    end
  end

  // Sign fix-up. A zero divisor makes the restoring loop produce an all-ones
  // quotient and leave |a| in the remainder; re-applying the dividend sign to
  // the remainder yields the raw dividend.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  assign prod_fix = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};

  always_comb begin
    fix_hi = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo = prod_fix[DATA_W-1:0];
    if (is_div_reg) begin
      fix_hi = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
      if (opb_reg == '0) begin
        fix_lo = '1;
      end else begin
        fix_lo = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opb_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (hilo_we[1]) hi_reg <= hi_in;
            if (hilo_we[0]) lo_reg <= lo_in;
            if (start) begin
              state_reg  <= CALC;
              cnt_reg    <= '0;
              acc_hi_reg <= '0;
              acc_lo_reg <= a_mag;
              opb_reg    <= b_mag;
              is_div_reg <= op[1];
              neg_q_reg  <= sa ^ sb;
              neg_r_reg  <= sa;
            end
          end
          CALC: begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(DATA_W - 1)) state_reg <= FIX;
          end
          FIX: begin
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);
  assign stall_req = busy & (start | rd_req | (|hilo_we));

endmodule

// File: tb/tb_hilo_muldiv.sv
// Testbench for hilo_muldiv: directed vectors with literal expectations plus a
// latency/arithmetic reference model compared on every falling clock edge.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  hilo_we = 2'b00;
  logic [31:0] hi_in = '0;
  logic [31:0] lo_in = '0;
  logic        rd_req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  hilo_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .rd_req(rd_req),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation as {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] op_v,
                                             input logic [31:0] av,
                                             input logic [31:0] bv);
    longint sp;
    int     q;
    int     r;
    case (op_v)
      2'b00: begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        return sp;
      end
      2'b01: return {32'd0, av} * {32'd0, bv};
      2'b10: begin
        if (bv == 32'd0) return {av, 32'hFFFFFFFF};
        if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(av) / $signed(bv);
        r = $signed(av) % $signed(bv);
        return {r, q};
      end
      default: begin
        if (bv == 32'd0) return {av, 32'hFFFFFFFF};
        return {av % bv, av / bv};
      end
    endcase
  endfunction

  // Reference model: an accepted op completes 33 edges after the start edge.
  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_left <= 0;
      end else if (m_left == 0) begin
        if (hilo_we[1]) m_hi <= hi_in;
        if (hilo_we[0]) m_lo <= lo_in;
        if (start) begin
          m_res  <= ref_result(op, a, b);
          m_left <= 33;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model hi", 64'(hi), 64'(m_hi));
    chk("model lo", 64'(lo), 64'(m_lo));
    chk("model busy", 64'(busy), 64'(m_left != 0));
    chk("model done", 64'(done), 64'(m_done));
    chk("model stall_req", 64'(stall_req),
        64'((m_left != 0) & (start | rd_req | (|hilo_we))));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op_v, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op = op_v;
    a = av;
    b = bv;
    cyc();
    start = 1'b0;
    a = 32'hDEADBEEF;   // latched operands must not follow later changes
    b = 32'h13579BDF;
  endtask

  task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el);
    int k;
    k = 0;
    while (k < 40) begin
      cyc();
      k++;
      if (done === 1'b1) break;
    end
    chk({name, " latency"}, 64'(k), 64'd33);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
  endtask

  logic [1:0]  t_op[6] = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [31:0] t_a[6]  = '{32'd7, 32'd100, 32'h80000000, 32'hFFFFFFF9, 32'h12345678, 32'h00010000};
  logic [31:0] t_b[6]  = '{32'hFFFFFFFE, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h00010000};
  logic [31:0] t_hi[6] = '{32'd1, 32'd2, 32'h40000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1};
  logic [31:0] t_lo[6] = '{32'hFFFFFFFD, 32'd14, 32'd0, 32'hFFFFFFFF, 32'hEDCBA988, 32'd0};

  initial begin
    // Pin the reference model with hand-computed results.
    chk("ref mult", ref_result(2'b00, 32'hFFFFFFFE, 32'd3), 64'hFFFFFFFF_FFFFFFFA);
    chk("ref multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("ref div", ref_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref divu0", ref_result(2'b11, 32'd7, 32'd0), 64'h00000007_FFFFFFFF);
    chk("ref divovf", ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    // Reset state.
    cyc();
    cyc();
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    resetn = 1'b1;
    cyc();

    // MTHI in idle.
    hilo_we = 2'b10;
    hi_in = 32'h1234;
    cyc();
    hilo_we = 2'b00;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo", 64'(lo), 64'h0);

    // MTLO together with MULT start: both take effect.
    hilo_we = 2'b01;
    lo_in = 32'h5678;
    issue(2'b00, 32'hFFFFFFFE, 32'd3);
    hilo_we = 2'b00;
    chk("mtlo+start lo", 64'(lo), 64'h5678);
    chk("mtlo+start busy", 64'(busy), 64'd1);
    cyc();
    cyc();
    // MTLO, MFLO and a new start while busy: stall, nothing changes.
    hilo_we = 2'b01;
    lo_in = 32'hDEAD;
    rd_req = 1'b1;
    start = 1'b1;
    op = 2'b11;
    #1;
    chk("busy stall_req", 64'(stall_req), 64'd1);
    cyc();
    hilo_we = 2'b00;
    rd_req = 1'b0;
    start = 1'b0;
    chk("busy mtlo lo", 64'(lo), 64'h5678);
    chk("busy preop hi", 64'(hi), 64'h1234);
    // Issue consumed edge N, two idle waits and the busy cycle consumed N+1..N+3.
    begin
      int k;
      k = 3;
      while (k < 40) begin
        cyc();
        k++;
        if (done === 1'b1) break;
      end
      chk("mult latency", 64'(k), 64'd33);
    end
    chk("mult hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult lo", 64'(lo), 64'hFFFFFFFA);
    rd_req = 1'b1;
    #1;
    chk("mflo after done stall_req", 64'(stall_req), 64'd0);
    cyc();
    rd_req = 1'b0;
    chk("done one cycle", 64'(done), 64'd0);

    // Back-to-back starts issued in the done cycle.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", 32'hFFFFFFFE, 32'h00000001);
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(2'b11, 32'd7, 32'd0);
    wait_done("divu 7/0", 32'd7, 32'hFFFFFFFF);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div ovf", 32'd0, 32'h80000000);
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done($sformatf("table %0d", i), t_hi[i], t_lo[i]);
    end
    cyc();

    // Flush at cycle 10 of a DIV, with a stray HI/LO write in the same cycle.
    issue(2'b10, 32'd100, 32'd3);
    repeat (9) cyc();
    flush = 1'b1;
    hilo_we = 2'b11;
    hi_in = 32'hAAAA;
    lo_in = 32'hBBBB;
    cyc();
    flush = 1'b0;
    hilo_we = 2'b00;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hi", 64'(hi), 64'd1);
    chk("flush lo", 64'(lo), 64'd0);
    repeat (30) cyc();
    chk("flush no late write", 64'(lo), 64'd0);

    // Flush landing on the FIX edge suppresses the write and done.
    issue(2'b01, 32'd9, 32'd9);
    repeat (32) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush fix done", 64'(done), 64'd0);
    chk("flush fix lo", 64'(lo), 64'd0);
    chk("flush fix busy", 64'(busy), 64'd0);

    // Flush in idle blocks MTHI/MTLO.
    flush = 1'b1;
    hilo_we = 2'b11;
    cyc();
    flush = 1'b0;
    hilo_we = 2'b00;
    chk("idle flush hi", 64'(hi), 64'd1);

    // Asynchronous reset at cycle 5 of a new op.
    issue(2'b00, 32'd5, 32'd6);
    repeat (4) cyc();
    resetn = 1'b0;
    #1;
    chk("async reset hi", 64'(hi), 64'd0);
    chk("async reset lo", 64'(lo), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();
    issue(2'b00, 32'd5, 32'hFFFFFFFA);
    wait_done("mult after reset", 32'hFFFFFFFF, 32'hFFFFFFE2);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
